reg_ps_controller: RTL
======================

# reg_ps_controller

Sequencing controller for a 4-bit parallel/serial shift register.
- Accepts a parallel word from an upstream requester over a valid/ready handshake and parallel-loads it into an internal shift register.
- Shifts the word out serially, LSB first, while capturing a serial input word into the same register.
- Presents the captured word in parallel with a one-cycle valid pulse.
- Sits between the register datapath and the block that owns the serial link. It provides the load/shift sequencing and bit counting that the bare register lacks.

## Interface

Parameters:
- NBITS_DATA, 4, word width in bits. Must be at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_valid  in  1  requester has a word on tx_data.
- tx_ready  out  1  controller accepts a word on this edge if tx_valid=1.
- tx_data  in  NBITS_DATA  parallel word to transmit.
- ser_in  in  1  serial data input; enters the register MSB.
- ser_out  out  1  serial data output; equals register bit 0 during shift cycles.
- ser_en  out  1  high during every cycle in which ser_out carries a valid bit.
- rx_valid  out  1  one-cycle pulse; rx_data (and par_err) updated.
- rx_data  out  NBITS_DATA  last captured serial word.
- busy  out  1  a transfer is in progress (state ≠ IDLE).
- par_err  out  1  parity mismatch on the last word; constant 0 when parity is compiled out.

## Operation

- State register with states IDLE, SHIFT and PARITY. PARITY exists only when parity is compiled in.
- Internal signals:
  - sreg[NBITS_DATA-1:0]: shift register.
  - cnt: bit counter, $clog2(NBITS_DATA) bits.
  - ptx: stored parity flop.
- IDLE:
  - tx_ready=1, ser_en=0, ser_out=0.
  - On tx_valid&tx_ready: parallel load sreg<=tx_data, cnt<=0, ptx<=^tx_data, go to SHIFT.
- SHIFT:
  - tx_ready=0, ser_en=1, ser_out=sreg[0].
  - Each edge: sreg<={ser_in, sreg[NBITS_DATA-1:1]}, cnt<=cnt+1.
  - When cnt==NBITS_DATA-1 (without parity):
    - rx_data<={ser_in, sreg[NBITS_DATA-1:1]}, rx_valid<=1.
    - Go to IDLE.
  - With parity: the same sreg update, then go to PARITY instead.
- Bit order:
  - First transmitted bit is tx_data[0].
  - First received bit lands in rx_data[0].
  - Last received bit lands in rx_data[NBITS_DATA-1].
- tx_data is sampled only at the accepting edge. Later changes are ignored.
- rx_data and par_err hold their values until the next completed transfer.
- Reset at any time:
  - The transfer in progress is aborted.
  - No rx_valid is produced for the aborted word.
  - All outputs return to reset values.

## Timing

- Reset values:
  - State=IDLE.
  - sreg=0, cnt=0, ptx=0.
  - tx_ready=1, ser_out=0, ser_en=0, busy=0.
  - rx_valid=0, rx_data=0, par_err=0.
- The accepting edge is edge k.
- Data bits:
  - Bits appear on ser_out in cycles k+1 … k+NBITS_DATA.
  - ser_in is sampled at the rising edge that ends each of those cycles.
- Without parity:
  - rx_valid=1 in cycle k+NBITS_DATA+1, while state is IDLE and tx_ready=1.
- Back-to-back transfers:
  - A new word may be accepted in the same cycle as rx_valid.
  - Sustained throughput is one word per NBITS_DATA+1 cycles, with ser_en low for exactly one cycle between words.
- Without parity, busy=1 in cycles k+1 … k+NBITS_DATA.
- rx_valid is never high for two consecutive cycles.

## Configuration

- Macro: REG_PS_PARITY_EN.
- Defined:
  - One extra serial cycle (state PARITY, cycle k+NBITS_DATA+1) follows the data bits, with ser_en=1 and ser_out=ptx (even parity of the transmitted word).
  - At the end of that cycle: rx_data<=sreg, par_err<=(ser_in != ^sreg), rx_valid<=1, go to IDLE.
  - Total cycles: rx_valid in k+NBITS_DATA+2; throughput is one word per NBITS_DATA+2 cycles.
- Undefined:
  - No PARITY state and no ptx flop.
  - par_err is tied to 0.
  - Timing is as given in the Timing section.

## Test plan

- Reset: assert reset mid-cycle with clk idle → all outputs at reset values immediately. tx_ready=1 after release.
- Single word (parity off): tx_data=4'b1011 accepted; ser_in=1,0,0,1 on the four shift cycles → ser_out=1,1,0,1 with ser_en=1 for exactly 4 cycles; rx_data=4'b1001; rx_valid high for 1 cycle at k+5.
- Back-to-back: tx_valid held high with 4'h5 then 4'hA; ser_in=0 → ser_out=1,0,1,0, then one gap cycle, then 0,1,0,1; two rx_valid pulses 5 cycles apart, each with rx_data=4'h0.
- Reset mid-transfer: assert reset after the 2nd shift cycle of 4'hF → ser_en drops and ser_out=0 immediately; no rx_valid; rx_data keeps its reset value 0; next word transfers normally.
- Hold and ignore: tx_valid=0 for 10 cycles → busy=0, ser_en=0, rx_valid=0. tx_data changed during SHIFT → transmitted bits unaffected.
- Parity (REG_PS_PARITY_EN):
  - tx_data=4'b0111 → ser_out=1,1,1,0, then parity bit 1.
  - ser_in=1,1,0,0, then parity 1 → rx_data=4'b0011, par_err=1, rx_valid at k+6.
  - Repeat with received parity 0 → par_err=0.

Source files
------------

// File: rtl/reg_ps_controller.sv
// Load/shift sequencer for a parallel/serial shift register: parallel word in, LSB-first serial out,
// serial word captured into the same register. Define REG_PS_PARITY_EN to append an even-parity bit.
module reg_ps_controller #(
    parameter int NBITS_DATA = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [NBITS_DATA-1:0] tx_data,
    input  logic                  ser_in,
    output logic                  ser_out,
    output logic                  ser_en,
    output logic                  rx_valid,
    output logic [NBITS_DATA-1:0] rx_data,
    output logic                  busy,
    output logic                  par_err
);
    localparam int CW = $clog2(NBITS_DATA);

`ifdef REG_PS_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t                state, state_nxt;
    logic [NBITS_DATA-1:0] sreg;
    logic [CW-1:0]         cnt;
    logic                  load, shift, done;
    logic                  cnt_last;
    logic                  ptx_bit;

    assign cnt_last = (cnt == CW'(NBITS_DATA - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_ready  = 1'b0;
        ser_en    = 1'b0;
        ser_out   = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ser_en  = 1'b1;
                ser_out = sreg[0];
                shift   = 1'b1;
                if (cnt_last) begin
`ifdef REG_PS_PARITY_EN
                    state_nxt = PARITY;
`else
                    done      = 1'b1;
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef REG_PS_PARITY_EN
            PARITY: begin
                ser_en    = 1'b1;
                ser_out   = ptx_bit;
                done      = 1'b1;
                state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Outgoing bits leave from bit 0 while incoming bits enter at the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg     <= '0;
            cnt      <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= done;
            if (load) begin
                sreg <= tx_data;
                cnt  <= '0;
            end else if (shift) begin
                sreg <= {ser_in, sreg[NBITS_DATA-1:1]};
                cnt  <= cnt + 1'b1;
            end
`ifdef REG_PS_PARITY_EN
            if (done) rx_data <= sreg;
`else
            if (done) rx_data <= {ser_in, sreg[NBITS_DATA-1:1]};
`endif
        end
    end

`ifdef REG_PS_PARITY_EN
    logic ptx, par_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptx       <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            if (load) ptx <= ^tx_data;
            if (done) par_err_q <= (ser_in != ^sreg);
        end
    end

    assign ptx_bit = ptx;
    assign par_err = par_err_q;
`else
    assign ptx_bit = 1'b0;
    assign par_err = 1'b0;
`endif

endmodule
